// File: rtl/uart_pkg.sv
// Shared constants, divisor FSM encoding and divisor clamp helper for uart_rx_ctrl.
package uart_pkg;

  localparam logic [31:0] DEFAULT_DIV  = 32'd104;
  localparam logic [31:0] MIN_DIV      = 32'd2;
  localparam int          TIMEOUT_BITS = 40;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } div_state_e;

  // The receiver derives its half-bit point as (div>>1)-1, so div must be at least 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of receiver-side and firmware-side signals of uart_rx_ctrl.
// to_flag exists only when UART_RX_TIMEOUT_EN is defined.
interface uart_rx_ctrl_if #(parameter int AW = 4);

  logic          rx_irq;
  logic [7:0]    rx_data;
  logic          rx_frame_err;
  logic          rx_busy;
  logic          rx_finish;
  logic [31:0]   clk_div;
  logic          cfg_we;
  logic [31:0]   cfg_wdata;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   thresh;
  logic          irq_clr;
  logic [AW:0]   fifo_count;
  logic          ovr_err;
  logic          frm_err;
  logic [7:0]    err_cnt;
  logic          irq;
`ifdef UART_RX_TIMEOUT_EN
  logic          to_flag;

  modport master (
    output rx_irq, rx_data, rx_frame_err, rx_busy, cfg_we, cfg_wdata, rd_req, thresh, irq_clr,
    input  rx_finish, clk_div, rd_data, rd_valid, fifo_count, ovr_err, frm_err, err_cnt, irq,
           to_flag
  );

  modport slave (
    input  rx_irq, rx_data, rx_frame_err, rx_busy, cfg_we, cfg_wdata, rd_req, thresh, irq_clr,
    output rx_finish, clk_div, rd_data, rd_valid, fifo_count, ovr_err, frm_err, err_cnt, irq,
           to_flag
  );
`else
  modport master (
    output rx_irq, rx_data, rx_frame_err, rx_busy, cfg_we, cfg_wdata, rd_req, thresh, irq_clr,
    input  rx_finish, clk_div, rd_data, rd_valid, fifo_count, ovr_err, frm_err, err_cnt, irq
  );

  modport slave (
    input  rx_irq, rx_data, rx_frame_err, rx_busy, cfg_we, cfg_wdata, rd_req, thresh, irq_clr,
    output rx_finish, clk_div, rd_data, rd_valid, fifo_count, ovr_err, frm_err, err_cnt, irq
  );
`endif

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with registered read port; a pop frees a slot for a same-cycle push.
// pop_ok_o is exported only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic          push_ok_o,
`ifdef UART_RX_TIMEOUT_EN
  output logic          pop_ok_o,
`endif
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_nxt_o,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          full, empty, push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= pop_ok;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) begin
        rptr_q    <= rptr_q + 1'b1;
        rd_data_q <= mem_q[rptr_q];
      end
    end
  end

  assign push_ok_o   = push_ok;
`ifdef UART_RX_TIMEOUT_EN
  assign pop_ok_o    = pop_ok;
`endif
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, error tracking, level IRQ and deferred divisor updates.
// Optional character-timeout detector is compiled in with UART_RX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | clk_div is current; an idle-time write applies next cycle
// PEND  | write arrived mid-frame; pend_div waits for rx_busy to fall
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          AW          = 4,
  parameter logic [31:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus
);

  logic [AW:0] count, count_nxt;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_valid;
  logic        push_ok;
`ifdef UART_RX_TIMEOUT_EN
  logic        pop_ok;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.rx_irq),
    .wdata_i     (bus.rx_data),
    .pop_i       (bus.rd_req),
    .push_ok_o   (push_ok),
`ifdef UART_RX_TIMEOUT_EN
    .pop_ok_o    (pop_ok),
`endif
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .rd_data_o   (fifo_rd_data),
    .rd_valid_o  (fifo_rd_valid)
  );

  logic        rx_finish_q;
  logic        ovr_q, ovr_d, frm_q, frm_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        irq_q, irq_d;
  logic        ovr_ev, frm_ev;
  logic [8:0]  err_sum;
  logic        thresh_hit;
  logic        to_d;

  assign ovr_ev = bus.rx_irq & ~push_ok;
  assign frm_ev = bus.rx_frame_err;

  // An error event in the same cycle as irq_clr survives the clear.
  always_comb begin
    ovr_d     = ovr_ev | (ovr_q & ~bus.irq_clr);
    frm_d     = frm_ev | (frm_q & ~bus.irq_clr);
    err_sum   = {1'b0, (bus.irq_clr ? 8'h00 : err_cnt_q)} + 9'(ovr_ev) + 9'(frm_ev);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign thresh_hit = (bus.thresh != '0) && (count_nxt >= bus.thresh);
  assign irq_d      = thresh_hit | ovr_d | frm_d | to_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_finish_q <= 1'b0;
      ovr_q       <= 1'b0;
      frm_q       <= 1'b0;
      err_cnt_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      rx_finish_q <= bus.rx_irq;
      ovr_q       <= ovr_d;
      frm_q       <= frm_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= irq_d;
    end
  end

  div_state_e  state_q, state_d;
  logic [31:0] clk_div_q, clk_div_d;
  logic [31:0] pend_div_q, pend_div_d;
  logic [31:0] wdiv;

  assign wdiv = clamp_div(bus.cfg_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_div_q  <= DEFAULT_DIV;
      pend_div_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_div_q  <= clk_div_d;
      pend_div_q <= pend_div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cfg_we && bus.rx_busy) state_d = PEND;
      PEND:    if (!bus.rx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clk_div_d  = clk_div_q;
    pend_div_d = pend_div_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          if (bus.rx_busy) pend_div_d = wdiv;
          else             clk_div_d  = wdiv;
        end
      end
      PEND: begin
        if (bus.cfg_we) pend_div_d = wdiv;
        if (!bus.rx_busy) clk_div_d = bus.cfg_we ? wdiv : pend_div_q;
      end
      default: ;
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [5:0]  bit_q, bit_d;
  logic        to_q;

  // Cycle timer counts down one bit time; the bit counter stops once it hits the limit.
  always_comb begin
    cyc_d = cyc_q;
    bit_d = bit_q;
    to_d  = to_q & ~(pop_ok | bus.irq_clr);
    if (push_ok || pop_ok) begin
      cyc_d = clk_div_q - 32'd1;
      bit_d = '0;
    end else if (count != '0 && !bus.rx_busy && bit_q != 6'(TIMEOUT_BITS)) begin
      if (cyc_q == '0) begin
        cyc_d = clk_div_q - 32'd1;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'(TIMEOUT_BITS - 1)) to_d = 1'b1;
      end else begin
        cyc_d = cyc_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= DEFAULT_DIV - 32'd1;
      bit_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      bit_q <= bit_d;
      to_q  <= to_d;
    end
  end

  assign bus.to_flag = to_q;
`else
  assign to_d = 1'b0;
`endif

  assign bus.rx_finish  = rx_finish_q;
  assign bus.clk_div    = clk_div_q;
  assign bus.rd_data    = fifo_rd_data;
  assign bus.rd_valid   = fifo_rd_valid;
  assign bus.fifo_count = count;
  assign bus.ovr_err    = ovr_q;
  assign bus.frm_err    = frm_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte scoreboard; timeout steps run when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mdl_count = 0;
  logic [7:0] sb [$];
  logic [7:0] e;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.AW(AW)) bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .DEFAULT_DIV(32'd104)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.rx_irq  = 1'b1;
    bus.rx_data = d;
    @(negedge clk);
    bus.rx_irq  = 1'b0;
    if (mdl_count < DEPTH) begin
      sb.push_back(d);
      mdl_count++;
    end
    chk("rx_finish_push", 32'(bus.rx_finish), 32'd1);
  endtask

  task automatic pop_one();
    logic [7:0] x;
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      mdl_count--;
      chk("rd_valid_pop", 32'(bus.rd_valid), 32'd1);
      chk("rd_data_pop", 32'(bus.rd_data), 32'(x));
    end else begin
      chk("rd_valid_empty", 32'(bus.rd_valid), 32'd0);
    end
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    bus.rx_irq       = 1'b0;
    bus.rx_data      = '0;
    bus.rx_frame_err = 1'b0;
    bus.rx_busy      = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_wdata    = '0;
    bus.rd_req       = 1'b0;
    bus.thresh       = '0;
    bus.irq_clr      = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);

    // 1: reset values and single byte round trip
    chk("rst_clk_div", bus.clk_div, 32'd104);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    push_byte(8'hA5);
    cycles(1);
    chk("rx_finish_once", 32'(bus.rx_finish), 32'd0);
    chk("count_one", 32'(bus.fifo_count), 32'd1);
    pop_one();
    cycles(1);
    chk("rd_valid_one_cycle", 32'(bus.rd_valid), 32'd0);

    // 2: overflow, ordered drain, clear
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    chk("full_count", 32'(bus.fifo_count), 32'd16);
    chk("ovr_set", 32'(bus.ovr_err), 32'd1);
    chk("ovr_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("ovr_irq", 32'(bus.irq), 32'd1);
    for (int i = 0; i < 16; i++) pop_one();
    chk("drained_count", 32'(bus.fifo_count), 32'd0);
    clear_irq();
    chk("clr_irq", 32'(bus.irq), 32'd0);
    chk("clr_ovr", 32'(bus.ovr_err), 32'd0);
    chk("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
    pop_one();
    chk("empty_rd_data_hold", 32'(bus.rd_data), 32'h0F);

    // 3: full FIFO, simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    bus.rx_irq  = 1'b1;
    bus.rx_data = 8'h30;
    bus.rd_req  = 1'b1;
    @(negedge clk);
    bus.rx_irq  = 1'b0;
    bus.rd_req  = 1'b0;
    e = sb.pop_front();
    sb.push_back(8'h30);
    chk("simul_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("simul_rd_data", 32'(bus.rd_data), 32'(e));
    chk("simul_count", 32'(bus.fifo_count), 32'd16);
    chk("simul_no_ovr", 32'(bus.ovr_err), 32'd0);
    chk("simul_rx_finish", 32'(bus.rx_finish), 32'd1);
    for (int i = 0; i < 16; i++) pop_one();

    // 4: data threshold IRQ
    bus.thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i));
    chk("thresh_below", 32'(bus.irq), 32'd0);
    push_byte(8'h53);
    chk("thresh_hit", 32'(bus.irq), 32'd1);
    pop_one();
    chk("thresh_pop", 32'(bus.irq), 32'd0);
    bus.thresh = '0;
    for (int i = 0; i < 3; i++) pop_one();

    // 5: deferred divisor writes and clamp
    bus.rx_busy   = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 32'h1B2;
    @(negedge clk);
    bus.cfg_wdata = 32'h36;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    chk("div_deferred", bus.clk_div, 32'd104);
    cycles(2);
    chk("div_still_deferred", bus.clk_div, 32'd104);
    bus.rx_busy = 1'b0;
    @(negedge clk);
    chk("div_applied", bus.clk_div, 32'h36);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 32'd1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    chk("div_clamp", bus.clk_div, 32'd2);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 32'd104;
    @(negedge clk);
    bus.cfg_we    = 1'b0;

    // mid-operation reset drops FIFO and pending divisor
    push_byte(8'h77);
    bus.rx_busy   = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 32'h99;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    mdl_count = 0;
    chk("midrst_count", 32'(bus.fifo_count), 32'd0);
    chk("midrst_div", bus.clk_div, 32'd104);
    rst_n = 1'b1;
    bus.rx_busy = 1'b0;
    cycles(2);
    chk("midrst_pend_lost", bus.clk_div, 32'd104);

    // 6: frame errors, saturation, clear collision, coincident events
    bus.rx_frame_err = 1'b1;
    cycles(300);
    bus.rx_frame_err = 1'b0;
    chk("frm_sat_cnt", 32'(bus.err_cnt), 32'hFF);
    chk("frm_flag", 32'(bus.frm_err), 32'd1);
    chk("frm_irq", 32'(bus.irq), 32'd1);
    chk("frm_no_push", 32'(bus.fifo_count), 32'd0);
    bus.rx_frame_err = 1'b1;
    bus.irq_clr      = 1'b1;
    @(negedge clk);
    bus.rx_frame_err = 1'b0;
    bus.irq_clr      = 1'b0;
    chk("clr_vs_frm_flag", 32'(bus.frm_err), 32'd1);
    chk("clr_vs_frm_cnt", 32'(bus.err_cnt), 32'd1);
    clear_irq();
    chk("clr_frm", 32'(bus.frm_err), 32'd0);
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
    bus.rx_irq       = 1'b1;
    bus.rx_data      = 8'hEE;
    bus.rx_frame_err = 1'b1;
    @(negedge clk);
    bus.rx_irq       = 1'b0;
    bus.rx_frame_err = 1'b0;
    chk("dual_err_cnt", 32'(bus.err_cnt), 32'd2);
    chk("dual_ovr", 32'(bus.ovr_err), 32'd1);
    for (int i = 0; i < 16; i++) pop_one();
    clear_irq();
    chk("final_irq", 32'(bus.irq), 32'd0);

`ifdef UART_RX_TIMEOUT_EN
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 32'd4;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    push_byte(8'h81);
    cycles(159);
    chk("to_not_yet", 32'(bus.to_flag), 32'd0);
    cycles(1);
    chk("to_flag", 32'(bus.to_flag), 32'd1);
    chk("to_irq", 32'(bus.irq), 32'd1);
    pop_one();
    chk("to_pop_clear", 32'(bus.to_flag), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller between the UART receiver (uart_receive) and the SoC register/firmware side.
- Owns the receiver's baud divisor. Captures each received byte into an internal FIFO and acknowledges the receiver with rx_finish.
- Tracks framing and overrun errors and raises a single level interrupt.
- Defers divisor changes until the receiver is idle, so a frame in progress is never corrupted.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, 4: log2(DEPTH).
- DEFAULT_DIV, 32'd104: clk_div value after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_irq  in  1  receiver byte-valid pulse; one cycle, rx_data valid that cycle
- rx_data  in  8  received byte
- rx_frame_err  in  1  receiver framing-error pulse
- rx_busy  in  1  receiver mid-frame
- rx_finish  out  1  one-cycle pulse: byte consumed (pushed or dropped)
- clk_div  out  32  divisor driven to the receiver
- cfg_we  in  1  divisor write strobe
- cfg_wdata  in  32  new divisor
- rd_req  in  1  firmware pop request
- rd_data  out  8  popped byte
- rd_valid  out  1  rd_data valid, one cycle
- thresh  in  AW+1  data-IRQ threshold; 0 disables the data IRQ
- irq_clr  in  1  clears sticky error flags
- fifo_count  out  AW+1  occupancy, 0..DEPTH
- ovr_err  out  1  sticky overrun flag
- frm_err  out  1  sticky framing-error flag
- err_cnt  out  8  saturating count of frame errors plus overruns
- irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: clk_div=DEFAULT_DIV; FIFO empty; every other output 0; divisor FSM in IDLE.
- Push path:
  - rx_irq with FIFO not full: write rx_data at wptr, wptr++ (wraps mod DEPTH).
  - rx_irq with FIFO full: byte dropped, ovr_err<=1, err_cnt++.
  - rx_finish pulses the cycle after rx_irq in both cases.
- Pop path:
  - rd_req with FIFO not empty: next cycle rd_data=mem[rptr], rd_valid=1, rptr++.
  - rd_req with FIFO empty: ignored; rd_valid=0, rd_data holds its last value.
- Simultaneous push and pop:
  - Both execute and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and no overrun is raised.
  - When empty, the pop is ignored and only the push occurs.
- Framing errors: rx_frame_err sets frm_err=1 and increments err_cnt. No push.
- err_cnt saturates at 8'hFF. If overrun and frame-error events coincide, err_cnt increments by 2, saturating.
- irq_clr: clears ovr_err, frm_err and err_cnt next cycle. An error event in the same cycle wins and leaves its flag set.
- irq = (thresh!=0 && fifo_count>=thresh) | ovr_err | frm_err [| to_flag]. Registered: asserts one cycle after the causing event.
- Divisor FSM, states IDLE and PEND:
  - IDLE, cfg_we, rx_busy=0: clk_div<=cfg_wdata next cycle; stay IDLE.
  - IDLE, cfg_we, rx_busy=1: latch pend_div, go PEND.
  - PEND, cfg_we: overwrite pend_div; last write wins.
  - PEND, rx_busy=0: clk_div<=pend_div, go IDLE.
  - cfg_wdata<2 is clamped to 2, because the receiver computes (div>>1)-1.
- Pointers are AW bits; count is AW+1 bits; full when count==DEPTH.
- Reset asserted mid-operation: FIFO contents discarded, pending divisor lost, clk_div returns to DEFAULT_DIV.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- When defined, a character-timeout detector is compiled in:
  - A cycle counter runs to clk_div-1, then increments a bit counter.
  - Both counters run only while fifo_count!=0 and rx_busy=0; a push or pop resets both.
  - The bit counter reaching 40 (4 character times) sets sticky to_flag, which ORs into irq and is exposed as output to_flag.
  - to_flag clears on a pop or irq_clr.
- When undefined: no counters, the to_flag port is absent, and irq omits the term.

Decomposition:
- Package uart_pkg: DEFAULT_DIV, MIN_DIV=2, TIMEOUT_BITS=40, divisor FSM state encodings (IDLE=1'b0, PEND=1'b1).
- Sub-module uart_rx_fifo: sync FIFO with push, pop, full, empty and count. The controller holds the error, IRQ, divisor and timeout logic.

Test Plan:
1. Reset -> clk_div=104, fifo_count=0, irq=0, rd_valid=0; push 8'hA5, rd_req -> rd_data=A5, rd_valid 1 cycle, rx_finish pulsed once.
2. Push 17 bytes 0x00..0x10 into a DEPTH=16 FIFO -> count=16, ovr_err=1, err_cnt=1, irq=1; pop 16 -> data 0x00..0x0F in order; irq_clr -> irq=0.
3. FIFO full, rx_irq and rd_req same cycle -> count stays 16, ovr_err=0, oldest byte returned.
4. thresh=4, push 3 -> irq=0; 4th push -> irq=1 next cycle; pop 1 -> irq=0.
5. rx_busy=1, cfg_we 0x1B2 then 0x36 -> clk_div stays 104; rx_busy falls -> clk_div=0x36 next cycle. Write 1 while idle -> clk_div=2.
6. 300 rx_frame_err pulses -> err_cnt=FF, frm_err=1. With UART_RX_TIMEOUT_EN, div=4, one byte buffered, idle for 160 cycles -> to_flag=1, irq=1.
